// File: rtl/fetch_unit.sv
// Two-phase instruction fetch: FETCH latches one ROM byte into instr/oprnd,
// EXEC lets decode steer the PC. Stalls in FETCH until the ROM byte is valid.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        incPC,
  input  logic        loadPC,
  input  logic [11:0] loadValue,
  input  logic [7:0]  prog_byte,
  input  logic        prog_valid,
  output logic        prog_req,
  output logic [11:0] pc,
  output logic        phase,
  output logic [3:0]  instr,
  output logic [3:0]  oprnd,
  output logic        stall
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state, stateNext;
  logic [11:0] pcNext, pcUpdate;
  logic [3:0]  instrNext, oprndNext;

  // loadPC outranks incPC; the 12-bit add wraps FFF -> 000 on its own
  always_comb begin
    pcUpdate = pc;
    if (loadPC)
      pcUpdate = loadValue;
    else if (incPC)
      pcUpdate = pc + 12'd1;
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = instr;
    oprndNext = oprnd;
    stall     = 1'b0;
    prog_req  = (state == FETCH);
    if (enable) begin
      unique case (state)
        FETCH: begin
          if (prog_valid) begin
            instrNext = prog_byte[7:4];
            oprndNext = prog_byte[3:0];
            pcNext    = pcUpdate;
            stateNext = EXEC;
          end else begin
            stall = 1'b1;
          end
        end
        EXEC: begin
          pcNext    = pcUpdate;
          stateNext = FETCH;
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      instr <= '0;
      oprnd <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      instr <= instrNext;
      oprnd <= oprndNext;
    end
  end

  assign phase = (state == EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: a table of per-cycle stimulus with
// expected pre-edge stall and post-edge registered state, plus reset sequences.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        incPC;
  logic        loadPC;
  logic [11:0] loadValue;
  logic [7:0]  prog_byte;
  logic        prog_valid;
  logic        prog_req;
  logic [11:0] pc;
  logic        phase;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        stall;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .incPC      (incPC),
    .loadPC     (loadPC),
    .loadValue  (loadValue),
    .prog_byte  (prog_byte),
    .prog_valid (prog_valid),
    .prog_req   (prog_req),
    .pc         (pc),
    .phase      (phase),
    .instr      (instr),
    .oprnd      (oprnd),
    .stall      (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        inc;
    logic        load;
    logic [11:0] lv;
    logic [7:0]  pbyte;
    logic        pvalid;
    logic        expStall;
    logic [11:0] expPc;
    logic        expPhase;
    logic [3:0]  expInstr;
    logic [3:0]  expOprnd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic inc, logic load, logic [11:0] lv,
                              logic [7:0] pbyte, logic pvalid, logic expStall,
                              logic [11:0] expPc, logic expPhase,
                              logic [3:0] expInstr, logic [3:0] expOprnd);
    vec_t v;
    v.en = en; v.inc = inc; v.load = load; v.lv = lv;
    v.pbyte = pbyte; v.pvalid = pvalid; v.expStall = expStall;
    v.expPc = expPc; v.expPhase = expPhase;
    v.expInstr = expInstr; v.expOprnd = expOprnd;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [11:0] ePc, input logic ePhase,
                            input logic [3:0] eInstr, input logic [3:0] eOprnd);
    check({tag, ".pc"}, pc, ePc);
    check({tag, ".phase"}, {11'd0, phase}, {11'd0, ePhase});
    check({tag, ".instr"}, {8'd0, instr}, {8'd0, eInstr});
    check({tag, ".oprnd"}, {8'd0, oprnd}, {8'd0, eOprnd});
    check({tag, ".prog_req"}, {11'd0, prog_req}, {11'd0, ~ePhase});
  endtask

  task automatic drive(input logic en, input logic inc, input logic load,
                       input logic [11:0] lv, input logic [7:0] pbyte, input logic pvalid);
    enable = en; incPC = inc; loadPC = load; loadValue = lv;
    prog_byte = pbyte; prog_valid = pvalid;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);

    // Asynchronous reset at time 1, well before the first rising edge
    #1 reset = 1'b1;
    #1 checkState("reset", 12'h000, 1'b0, 4'h0, 4'h0);
    @(negedge clock);
    reset = 1'b0;

    //            en inc ld  lv      byte   pv  stall pc      ph  instr oprnd
    vecs.push_back(mk(1, 1, 0, 12'h000, 8'h4A, 1, 0, 12'h001, 1, 4'h4, 4'hA)); // V-1
    vecs.push_back(mk(1, 1, 1, 12'h3C5, 8'h00, 0, 0, 12'h3C5, 0, 4'h4, 4'hA)); // V-2 load wins
    vecs.push_back(mk(1, 1, 0, 12'h000, 8'hFF, 0, 1, 12'h3C5, 0, 4'h4, 4'hA)); // V-4 stall x3
    vecs.push_back(mk(1, 1, 1, 12'h111, 8'hFF, 0, 1, 12'h3C5, 0, 4'h4, 4'hA));
    vecs.push_back(mk(1, 1, 0, 12'h000, 8'hFF, 0, 1, 12'h3C5, 0, 4'h4, 4'hA));
    vecs.push_back(mk(1, 0, 0, 12'h000, 8'h9E, 1, 0, 12'h3C5, 1, 4'h9, 4'hE)); // latch after stall
    vecs.push_back(mk(1, 0, 1, 12'hFFF, 8'h00, 0, 0, 12'hFFF, 0, 4'h9, 4'hE));
    vecs.push_back(mk(1, 0, 0, 12'h000, 8'h12, 1, 0, 12'hFFF, 1, 4'h1, 4'h2));
    vecs.push_back(mk(1, 1, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 4'h1, 4'h2)); // V-3 wrap
    vecs.push_back(mk(0, 1, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 4'h1, 4'h2)); // enable=0: no stall
    vecs.push_back(mk(1, 0, 1, 12'h2A0, 8'hC7, 1, 0, 12'h2A0, 1, 4'hC, 4'h7));
    for (int k = 0; k < 5; k++)                                                 // V-5 freeze
      vecs.push_back(mk(0, 1, 1, 12'h555, 8'hEE, 1, 0, 12'h2A0, 1, 4'hC, 4'h7));
    vecs.push_back(mk(1, 1, 1, 12'h555, 8'hEE, 1, 0, 12'h555, 0, 4'hC, 4'h7));
    vecs.push_back(mk(1, 1, 0, 12'h000, 8'h35, 1, 0, 12'h556, 1, 4'h3, 4'h5));
    vecs.push_back(mk(1, 0, 0, 12'h000, 8'hFF, 1, 0, 12'h556, 0, 4'h3, 4'h5)); // EXEC ignores byte
    vecs.push_back(mk(1, 0, 1, 12'h2A0, 8'h2A, 1, 0, 12'h2A0, 1, 4'h2, 4'hA));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].en, vecs[i].inc, vecs[i].load, vecs[i].lv, vecs[i].pbyte, vecs[i].pvalid);
      #1 check($sformatf("v%0d.stall", i), {11'd0, stall}, {11'd0, vecs[i].expStall});
      @(posedge clock);
      #1 checkState($sformatf("v%0d", i), vecs[i].expPc, vecs[i].expPhase,
                    vecs[i].expInstr, vecs[i].expOprnd);
    end

    // V-6: now in EXEC at pc=2A0; reset mid-cycle clears state before any edge
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b1, 12'h777, 8'h66, 1'b1);
    reset = 1'b1;
    #1 checkState("midExecReset", 12'h000, 1'b0, 4'h0, 4'h0);
    @(posedge clock);
    #1 checkState("heldReset", 12'h000, 1'b0, 4'h0, 4'h0);

    // After release, an edge with enable=0 must not advance anything
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 12'h000, 8'h81, 1'b1);
    @(posedge clock);
    #1 checkState("postResetIdle", 12'h000, 1'b0, 4'h0, 4'h0);

    // First enabled edge fetches from address 0
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h81, 1'b1);
    #1 check("firstFetchAddr", pc, 12'h000);
    @(posedge clock);
    #1 checkState("firstFetch", 12'h001, 1'b1, 4'h8, 4'h1);

    // Reset during a stalled FETCH abandons it
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0);
    #1 check("stallBeforeReset", {11'd0, stall}, 12'h001);
    reset = 1'b1;
    #1 checkState("stallReset", 12'h000, 1'b0, 4'h0, 4'h0);
    @(negedge clock);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
